// File: rtl/gsau_wb_buffer.sv
// GSAU writeback buffer: a first-word-fall-through circular FIFO of {vdst, psum}
// entries that drains into the vector register file and reports each commit.
module gsau_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 512,
    parameter int ADDR_W = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     wb_valid,
    input  logic [DATA_W-1:0]        wb_psum,
    input  logic [ADDR_W-1:0]        wb_wbdst,
    output logic                     wb_output_ready,
    output logic                     vrf_wen,
    output logic [ADDR_W-1:0]        vrf_waddr,
    output logic [DATA_W-1:0]        vrf_wdata,
    input  logic                     vrf_wack,
    output logic                     sb_wb_done,
    output logic [ADDR_W-1:0]        sb_wb_vdst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              sb_done_q, sb_done_d;
    logic [ADDR_W-1:0] sb_vdst_q, sb_vdst_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic              push, pop;
    logic [EW-1:0]     head_entry;

    always_comb begin
        wb_output_ready = (count_q != FULL);
        vrf_wen         = (count_q != '0);
        head_entry      = vrf_wen ? mem_q[head_q] : '0;
        vrf_waddr       = head_entry[EW-1:DATA_W];
        vrf_wdata       = head_entry[DATA_W-1:0];
        push            = wb_valid && wb_output_ready;
        pop             = vrf_wen && vrf_wack;
        count           = count_q;
        sb_wb_done      = sb_done_q;
        sb_wb_vdst      = sb_vdst_q;
    end

    // Pointers wrap for free since DEPTH is a power of two.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        sb_done_d = pop;
        sb_vdst_d = pop ? vrf_waddr : '0;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            sb_done_q <= 1'b0;
            sb_vdst_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            sb_done_q <= sb_done_d;
            sb_vdst_q <= sb_vdst_d;
        end
    end

    // Storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) mem_q[tail_q] <= {wb_wbdst, wb_psum};
    end

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Bench for gsau_wb_buffer: vector table for the basic flow, a queue model that
// tracks accepted and committed entries, and sequences for the multi-cycle cases.
module tb_gsau_wb_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 8;
    localparam int EW     = ADDR_W + DATA_W;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic                   wb_valid;
    logic [DATA_W-1:0]      wb_psum;
    logic [ADDR_W-1:0]      wb_wbdst;
    logic                   wb_output_ready;
    logic                   vrf_wen;
    logic [ADDR_W-1:0]      vrf_waddr;
    logic [DATA_W-1:0]      vrf_wdata;
    logic                   vrf_wack;
    logic                   sb_wb_done;
    logic [ADDR_W-1:0]      sb_wb_vdst;
    logic [$clog2(DEPTH):0] count;

    gsau_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .wb_valid(wb_valid), .wb_psum(wb_psum), .wb_wbdst(wb_wbdst),
        .wb_output_ready(wb_output_ready),
        .vrf_wen(vrf_wen), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .vrf_wack(vrf_wack),
        .sb_wb_done(sb_wb_done), .sb_wb_vdst(sb_wb_vdst), .count(count)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] acc_q[$];
    logic [EW-1:0] commit_q[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       wack;
        int         cnt;
        logic       rdy;
        logic       wen;
        logic [7:0] waddr;
        logic       done;
        logic [7:0] sdst;
    } vec_t;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [ADDR_W-1:0] d, input logic wack);
        logic [7:0] salt;
        salt     = 8'($urandom);
        wb_valid = v;
        wb_wbdst = d;
        wb_psum  = {(DATA_W/8){salt}};
        vrf_wack = wack;
    endtask

    // Model step, evaluated at the negedge before the edge it predicts.
    task automatic mon();
        logic [EW-1:0] e;
        logic          full;
        if (sb_wb_done) begin
            if (commit_q.size() == 0) chk("spurious_done", sb_wb_done, 0);
            else begin
                e = commit_q.pop_front();
                chk("commit_vdst", sb_wb_vdst, e[EW-1:DATA_W]);
            end
        end else chk("vdst_idle_zero", sb_wb_vdst, 0);
        chk("count", count, acc_q.size());
        chk("ready", wb_output_ready, acc_q.size() != DEPTH);
        chk("wen", vrf_wen, acc_q.size() != 0);
        if (acc_q.size() != 0) begin
            e = acc_q[0];
            chk("head_waddr", vrf_waddr, e[EW-1:DATA_W]);
            chk("head_wdata", vrf_wdata, e[DATA_W-1:0]);
        end else begin
            chk("empty_waddr", vrf_waddr, 0);
            chk("empty_wdata", vrf_wdata, 0);
        end
        full = (acc_q.size() == DEPTH);
        if (acc_q.size() != 0 && vrf_wack) commit_q.push_back(acc_q.pop_front());
        if (wb_valid && !full) acc_q.push_back({wb_wbdst, wb_psum});
    endtask

    task automatic tick();
        @(negedge CLK);
        if (nRST) mon();
        else begin
            acc_q.delete();
            commit_q.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[13];
    int   run;
    int   ndone;
    logic [7:0] got[8];
    logic acc;

    initial begin
        vecs[0]  = '{1, 8'h05, 1, 1, 1, 1, 8'h05, 0, 8'h00};
        vecs[1]  = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 8'h05};
        vecs[2]  = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00};
        vecs[3]  = '{1, 8'h10, 0, 1, 1, 1, 8'h10, 0, 8'h00};
        vecs[4]  = '{0, 8'h00, 0, 1, 1, 1, 8'h10, 0, 8'h00};
        vecs[5]  = '{0, 8'h00, 0, 1, 1, 1, 8'h10, 0, 8'h00};
        vecs[6]  = '{0, 8'h00, 0, 1, 1, 1, 8'h10, 0, 8'h00};
        vecs[7]  = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 8'h10};
        vecs[8]  = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'h00};
        vecs[9]  = '{1, 8'h20, 1, 1, 1, 1, 8'h20, 0, 8'h00};
        vecs[10] = '{1, 8'h21, 1, 1, 1, 1, 8'h21, 1, 8'h20};
        vecs[11] = '{0, 8'h00, 0, 1, 1, 1, 8'h21, 0, 8'h00};
        vecs[12] = '{0, 8'h00, 1, 0, 1, 0, 8'h00, 1, 8'h21};

        nRST = 1'b0;
        set_in(0, 0, 0);
        #7;
        chk("rst_count", count, 0);
        chk("rst_ready", wb_output_ready, 1);
        chk("rst_wen", vrf_wen, 0);
        chk("rst_waddr", vrf_waddr, 0);
        chk("rst_wdata", vrf_wdata, 0);
        chk("rst_done", sb_wb_done, 0);
        chk("rst_vdst", sb_wb_vdst, 0);
        @(posedge CLK);
        #2 nRST = 1'b1;

        // Single entry, stall on head, push into empty with wack high, push+pop at count 1.
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].v, vecs[i].d, vecs[i].wack);
            if (i == 0) wb_psum = {(DATA_W/8){8'hA5}};
            tick();
            chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("vec%0d_ready", i), wb_output_ready, vecs[i].rdy);
            chk($sformatf("vec%0d_wen", i), vrf_wen, vecs[i].wen);
            chk($sformatf("vec%0d_waddr", i), vrf_waddr, vecs[i].waddr);
            chk($sformatf("vec%0d_done", i), sb_wb_done, vecs[i].done);
            chk($sformatf("vec%0d_sdst", i), sb_wb_vdst, vecs[i].sdst);
            if (i == 0) chk("vec0_wdata", vrf_wdata, {(DATA_W/8){8'hA5}});
        end

        // Fill with backpressure, held 5th entry, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            set_in(1, ADDR_W'(i), 0);
            tick();
        end
        chk("fill_count", count, 4);
        chk("fill_ready", wb_output_ready, 0);
        set_in(1, 8'h05, 0);
        tick();
        tick();
        chk("held_count", count, 4);
        vrf_wack = 1'b1;
        run = 0;
        for (int c = 0; c < 20; c++) begin
            acc = wb_valid && wb_output_ready;
            tick();
            if (acc) wb_valid = 1'b0;
            if (sb_wb_done) begin
                if (run < 8) got[run] = sb_wb_vdst;
                run++;
            end else if (run > 0) break;
        end
        chk("drain_run_len", run, 5);
        for (int k = 0; k < 5; k++) chk($sformatf("drain_order%0d", k), got[k], k + 1);
        chk("drain_count", count, 0);

        // Steady push+pop at count 2 across pointer wrap.
        set_in(1, 8'h50, 0);
        tick();
        set_in(1, 8'h51, 0);
        tick();
        chk("pp_count_init", count, 2);
        for (int i = 0; i < 10; i++) begin
            set_in(1, ADDR_W'(8'h60 + i), 1);
            tick();
            chk($sformatf("pp_count%0d", i), count, 2);
        end
        set_in(0, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("pp_drained", count, 0);

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) begin
            set_in(1, ADDR_W'(8'h30 + i), 0);
            tick();
        end
        set_in(0, 0, 0);
        chk("pre_rst_count", count, 3);
        #2 nRST = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_ready", wb_output_ready, 1);
        chk("arst_wen", vrf_wen, 0);
        chk("arst_waddr", vrf_waddr, 0);
        chk("arst_wdata", vrf_wdata, 0);
        chk("arst_done", sb_wb_done, 0);
        chk("arst_vdst", sb_wb_vdst, 0);
        acc_q.delete();
        commit_q.delete();
        tick();
        #2 nRST = 1'b1;
        set_in(1, 8'h40, 1);
        tick();
        chk("first_push_count", count, 1);
        chk("first_push_waddr", vrf_waddr, 8'h40);
        set_in(0, 0, 1);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sb_wb_done) begin
                ndone++;
                chk("post_rst_vdst", sb_wb_vdst, 8'h40);
            end
        end
        chk("post_rst_pulses", ndone, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gsau_wb_buffer.md
GSAU_WB_BUFFER -- requirements
Module: gsau_wb_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered writeback entries; it SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL have parameter DATA_W, default 512, giving the psum width in bits.
REQ-003 The block SHALL have parameter ADDR_W, default 8, giving the destination vector register index width.
REQ-004 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 wb_valid  input  1  GSAU presents a writeback entry.
REQ-007 wb_psum  input  DATA_W  psum payload of the presented entry.
REQ-008 wb_wbdst  input  ADDR_W  destination vreg of the presented entry.
REQ-009 wb_output_ready  output  1  buffer can accept an entry this cycle.
REQ-010 vrf_wen  output  1  head entry write request to the vector register file.
REQ-011 vrf_waddr  output  ADDR_W  head entry destination.
REQ-012 vrf_wdata  output  DATA_W  head entry payload.
REQ-013 vrf_wack  input  1  register file accepts the write this cycle; it may be low because of a bank conflict.
REQ-014 sb_wb_done  output  1  one-cycle pulse: a writeback committed.
REQ-015 sb_wb_vdst  output  ADDR_W  vreg committed; valid only while sb_wb_done is 1.
REQ-016 count  output  $clog2(DEPTH)+1  number of buffered entries.

Function
REQ-017 Storage SHALL be a circular FIFO with a head pointer, a tail pointer and count; both pointers SHALL wrap modulo DEPTH.
REQ-018 wb_output_ready SHALL equal (count != DEPTH) combinationally; it SHALL NOT depend on wb_valid or vrf_wack.
REQ-019 Push: when wb_valid && wb_output_ready, the block SHALL write {wb_wbdst, wb_psum} at the tail and advance the tail.
REQ-020 When wb_valid is high and wb_output_ready is low, the block SHALL ignore the entry with no state change; the sender holds the entry.
REQ-021 The buffer SHALL be first-word-fall-through.
  - vrf_wen = (count != 0).
  - vrf_waddr and vrf_wdata SHALL show the head entry, and SHALL be 0 when empty.
REQ-022 Pop: when vrf_wen && vrf_wack, the block SHALL advance the head; when vrf_wen is 0, vrf_wack SHALL be ignored.
REQ-023 vrf_waddr and vrf_wdata SHALL stay stable while vrf_wen && !vrf_wack.
REQ-024 count next value:
  - count + 1 on push only;
  - count - 1 on pop only;
  - unchanged on simultaneous push and pop, or on neither.
REQ-025 Simultaneous push and pop SHALL be legal at any count below DEPTH; at count = DEPTH no push occurs, so there is no pass-through.
REQ-026 Latency: an entry pushed into an empty buffer at edge N SHALL appear on vrf_wen/vrf_waddr/vrf_wdata in the cycle after edge N; there is no combinational path from wb_* to vrf_*.
REQ-027 Commit report: a pop at edge N SHALL cause sb_wb_done = 1 and sb_wb_vdst = popped vdst for exactly the cycle after edge N (registered outputs).
REQ-028 With back-to-back pops, sb_wb_done SHALL stay 1 and sb_wb_vdst SHALL update every cycle.
REQ-029 sb_wb_vdst SHALL be 0 whenever sb_wb_done is 0.
REQ-030 Entries SHALL commit in acceptance order; duplicate vdsts SHALL each commit separately, with no merging.

Reset
REQ-031 While nRST = 0, the block SHALL hold count = 0, both pointers = 0, vrf_wen = 0, vrf_waddr = 0, vrf_wdata = 0, sb_wb_done = 0, sb_wb_vdst = 0 and wb_output_ready = 1.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries without issuing sb_wb_done pulses; storage contents need not be cleared.
REQ-033 The first push SHALL be accepted on the first rising edge after nRST deasserts.

Verification
REQ-034 Single entry: push vdst=0x05, psum=0xA5 replicated, vrf_wack=1 -> vrf_wen=1 the next cycle with waddr=0x05; the cycle after that, sb_wb_done=1 with sb_wb_vdst=0x05 and count returns to 0.
REQ-035 Fill/backpressure: vrf_wack=0, push vdsts 1,2,3,4 -> count=4 and wb_output_ready=0; a held 5th entry (vdst=5) is not taken; raise vrf_wack -> commits occur in order 1,2,3,4,5, with sb_wb_done high for 5 consecutive cycles.
REQ-036 Bank-conflict stall: head vdst=0x10 with vrf_wack=0 for 3 cycles -> vrf_waddr/vrf_wdata stable and no sb_wb_done; vrf_wack=1 -> exactly one pulse with vdst 0x10.
REQ-037 Simultaneous push and pop at count=2 -> count stays 2, and order is preserved across pointer wrap after 10 continuous cycles.
REQ-038 Reset mid-operation: nRST pulsed low asynchronously with count=3 -> all outputs go to reset values immediately, and no sb_wb_done pulse occurs afterward for the discarded entries.
